// File: rtl/ascon_absorb.sv
// Ascon sponge absorb stage: loads the initial state, XORs padded rate blocks
// into x0 and sequences the round-based permutation core between blocks.
module ascon_absorb #(
    parameter int unsigned ROUNDS = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         init_valid,
    input  logic [319:0] init_state,
    output logic         init_ready,
    input  logic         msg_valid,
    input  logic [63:0]  msg_data,
    input  logic [3:0]   msg_bytes,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic [4:0]   perm_ctr,
    output logic [4:0]   perm_rounds,
    output logic         perm_start,
    output logic [319:0] perm_S,
    input  logic [319:0] perm_out,
    input  logic         perm_done,
    output logic         out_valid,
    output logic [319:0] out_state,
    input  logic         out_ready
);

    localparam logic [4:0]  RND = 5'(ROUNDS);
    localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {IDLE, ABSORB, P_LOAD, P_RUN, P_WAIT, DONE} state_t;

    state_t         state;
    logic [319:0]   st;
    logic [4:0]     ctr;
    logic           pad_pending;
    logic           last;
    logic [63:0]    pb;
    logic [31:0]    nb;

    // Padded block: keep nb leading bytes, 0x80 right after them, zeros beyond.
    always_comb begin
        nb = {28'd0, msg_bytes};
        if (nb > 32'd8) nb = 32'd8;
        pb = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < nb)
                pb[63-8*i -: 8] = msg_data[63-8*i -: 8];
            else if (i == nb)
                pb[63-8*i -: 8] = 8'h80;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            st          <= '0;
            ctr         <= '0;
            pad_pending <= 1'b0;
            last        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (init_valid) begin
                        st    <= init_state;
                        state <= ABSORB;
                    end
                end
                ABSORB: begin
                    if (msg_valid) begin
                        st[319:256] <= st[319:256] ^ pb;
                        last        <= msg_last;
                        pad_pending <= msg_last && (msg_bytes >= 4'd8);
                        state       <= P_LOAD;
                    end
                end
                P_LOAD: begin
                    ctr   <= 5'd1;
                    state <= P_RUN;
                end
                P_RUN: begin
                    if (ctr == RND) state <= P_WAIT;
                    else            ctr   <= ctr + 5'd1;
                end
                P_WAIT: begin
                    if (perm_done) begin
                        // A full last block still owes a padding-only block.
                        if (pad_pending) begin
                            st          <= {perm_out[319:256] ^ PAD, perm_out[255:0]};
                            pad_pending <= 1'b0;
                            state       <= P_LOAD;
                        end else begin
                            st    <= perm_out;
                            state <= last ? DONE : ABSORB;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign init_ready  = (state == IDLE);
    assign msg_ready   = (state == ABSORB);
    assign perm_start  = (state == P_LOAD) || (state == P_RUN);
    assign perm_ctr    = (state == P_RUN) ? ctr : ((state == P_WAIT) ? RND : 5'd0);
    assign perm_rounds = RND;
    assign perm_S      = st;
    assign out_valid   = (state == DONE);
    assign out_state   = (state == DONE) ? st : '0;

endmodule

// File: tb/tb_ascon_absorb.sv
// Directed bench for ascon_absorb, with a toy round function standing in for
// the permutation core (same load/ctr/done handshake as the real core).
module tb_ascon_absorb;

    localparam logic [63:0] PAD = 64'h8000_0000_0000_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         init_valid = 1'b0;
    logic [319:0] init_state = '0;
    logic         init_ready;
    logic         msg_valid = 1'b0;
    logic [63:0]  msg_data = '0;
    logic [3:0]   msg_bytes = '0;
    logic         msg_last = 1'b0;
    logic         msg_ready;
    logic [4:0]   perm_ctr, perm_rounds;
    logic         perm_start;
    logic [319:0] perm_S;
    logic         out_valid;
    logic [319:0] out_state;
    logic         out_ready = 1'b0;
    logic [319:0] core;
    logic         core_done;

    logic         init_valid6 = 1'b0;
    logic         init_ready6;
    logic         msg_valid6 = 1'b0;
    logic         msg_ready6;
    logic [4:0]   perm_ctr6, perm_rounds6;
    logic         perm_start6;
    logic [319:0] perm_S6;
    logic         out_valid6;
    logic [319:0] out_state6;
    logic [319:0] core6;
    logic         core_done6;

    int unsigned n_chk = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ascon_absorb #(.ROUNDS(12)) dut (
        .clk(clk), .rst(rst),
        .init_valid(init_valid), .init_state(init_state), .init_ready(init_ready),
        .msg_valid(msg_valid), .msg_data(msg_data), .msg_bytes(msg_bytes),
        .msg_last(msg_last), .msg_ready(msg_ready),
        .perm_ctr(perm_ctr), .perm_rounds(perm_rounds), .perm_start(perm_start),
        .perm_S(perm_S), .perm_out(core), .perm_done(core_done),
        .out_valid(out_valid), .out_state(out_state), .out_ready(out_ready)
    );

    ascon_absorb #(.ROUNDS(6)) dut6 (
        .clk(clk), .rst(rst),
        .init_valid(init_valid6), .init_state(320'd0), .init_ready(init_ready6),
        .msg_valid(msg_valid6), .msg_data(64'h0102030405060708), .msg_bytes(4'd8),
        .msg_last(1'b0), .msg_ready(msg_ready6),
        .perm_ctr(perm_ctr6), .perm_rounds(perm_rounds6), .perm_start(perm_start6),
        .perm_S(perm_S6), .perm_out(core6), .perm_done(core_done6),
        .out_valid(out_valid6), .out_state(out_state6), .out_ready(1'b1)
    );

    function automatic logic [319:0] rnd(input logic [319:0] s, input logic [4:0] c);
        return {s[318:0], s[319]} ^ {s[63:0], 256'd0} ^ {315'd0, c};
    endfunction

    function automatic logic [319:0] perm_ref(input logic [319:0] s, input int unsigned r);
        logic [319:0] t = s;
        for (int unsigned i = 1; i <= r; i++) t = rnd(t, 5'(i));
        return t;
    endfunction

    // Core stand-in: load on ctr 0, one round per later ctr, done one cycle after ctr = rounds.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            core <= '0; core_done <= 1'b0; core6 <= '0; core_done6 <= 1'b0;
        end else begin
            if (perm_start)  core  <= (perm_ctr == 5'd0)  ? perm_S  : rnd(core, perm_ctr);
            if (perm_start6) core6 <= (perm_ctr6 == 5'd0) ? perm_S6 : rnd(core6, perm_ctr6);
            core_done  <= perm_start  && (perm_ctr == perm_rounds);
            core_done6 <= perm_start6 && (perm_ctr6 == perm_rounds6);
        end
    end

    task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_init(input logic [319:0] s);
        int unsigned n = 0;
        init_valid = 1'b1; init_state = s;
        while (!init_ready && n < 100) begin tick(); n++; end
        check("init_ready_wait", 320'(init_ready), 320'(1));
        tick();
        init_valid = 1'b0;
    endtask

    // Returns just after the accept edge, i.e. in the P_LOAD cycle.
    task automatic send_block(input logic [63:0] d, input logic [3:0] nbytes, input logic lst);
        int unsigned n = 0;
        msg_valid = 1'b1; msg_data = d; msg_bytes = nbytes; msg_last = lst;
        while (!msg_ready && n < 100) begin tick(); n++; end
        check("msg_ready_wait", 320'(msg_ready), 320'(1));
        tick();
        msg_valid = 1'b0; msg_last = 1'b0;
    endtask

    task automatic run_to_done(output int unsigned cyc, output int unsigned loads,
                               output int unsigned rdy, output logic [319:0] last_s);
        cyc = 0; loads = 0; rdy = 0; last_s = '0;
        while (!out_valid && cyc < 200) begin
            if (perm_start && perm_ctr == 5'd0) begin loads++; last_s = perm_S; end
            if (msg_ready) rdy++;
            tick();
            cyc++;
        end
        check("out_valid_wait", 320'(out_valid), 320'(1));
    endtask

    task automatic release_out();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [319:0] s0, st1, st2, st3, exp_s, ls;
        int unsigned cyc, loads, rdy, n, bad;

        s0 = {64'h0011223344556677, 64'h8899AABBCCDDEEFF, 64'h0F1E2D3C4B5A6978,
              64'hDEADBEEFCAFEF00D, 64'h13579BDF02468ACE};

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_init_ready", 320'(init_ready), 320'(1));
        check("rst_msg_ready", 320'(msg_ready), 320'(0));
        check("rst_perm_start", 320'(perm_start), 320'(0));
        check("rst_perm_ctr", 320'(perm_ctr), 320'(0));
        check("rst_perm_S", perm_S, 320'd0);
        check("rst_out_valid", 320'(out_valid), 320'(0));
        check("rst_out_state", out_state, 320'd0);
        check("rst_perm_rounds", 320'(perm_rounds), 320'(12));
        check("rst_perm_rounds6", 320'(perm_rounds6), 320'(6));
        rst = 1'b1;
        tick();

        // Reset in the middle of P_RUN
        do_init(s0);
        send_block(64'hFEDCBA9876543210, 4'd8, 1'b0);
        n = 0;
        while (perm_ctr != 5'd5 && n < 30) begin tick(); n++; end
        check("mid_run_ctr", 320'(perm_ctr), 320'(5));
        rst = 1'b0; #3; rst = 1'b1;
        tick();
        check("mr_init_ready", 320'(init_ready), 320'(1));
        check("mr_perm_start", 320'(perm_start), 320'(0));
        check("mr_perm_ctr", 320'(perm_ctr), 320'(0));
        check("mr_out_valid", 320'(out_valid), 320'(0));
        check("mr_perm_S", perm_S, 320'd0);

        // Zero init, one last block of 3 bytes
        do_init(320'd0);
        send_block(64'h0123456789ABCDEF, 4'd3, 1'b1);
        st1 = {64'h0123458000000000, 256'd0};
        check("a_load_S", perm_S, st1);
        check("a_load_start", 320'(perm_start), 320'(1));
        check("a_ctr_0", 320'(perm_ctr), 320'(0));
        bad = 0;
        for (int unsigned k = 1; k <= 12; k++) begin
            tick();
            if (perm_ctr !== 5'(k) || !perm_start) bad++;
        end
        check("a_ctr_seq_errs", 320'(bad), 320'(0));
        tick();
        check("a_wait_start", 320'(perm_start), 320'(0));
        check("a_wait_ctr", 320'(perm_ctr), 320'(12));
        check("a_wait_out_valid", 320'(out_valid), 320'(0));
        tick();
        // 14 edges after the accept edge, i.e. the 15th cycle counting the accept cycle
        check("a_out_valid", 320'(out_valid), 320'(1));
        exp_s = perm_ref(st1, 12);
        check("a_out_state", out_state, exp_s);

        // DONE hold with stray handshakes
        bad = 0;
        for (int unsigned i = 0; i < 20; i++) begin
            init_valid = i[0]; msg_valid = ~i[0];
            tick();
            if (out_state !== exp_s || init_ready || msg_ready || !out_valid) bad++;
        end
        init_valid = 1'b0; msg_valid = 1'b0;
        check("hold_errs", 320'(bad), 320'(0));
        release_out();
        check("hold_release_init_ready", 320'(init_ready), 320'(1));
        check("hold_release_out_valid", 320'(out_valid), 320'(0));

        // Two blocks, the last one full: an extra padding permutation follows
        do_init(s0);
        send_block(64'h1111111111111111, 4'hF, 1'b0);
        st1 = s0 ^ {64'h1111111111111111, 256'd0};
        check("b_load1_S", perm_S, st1);
        send_block(64'hA5A5A5A5A5A5A5A5, 4'd8, 1'b1);
        st2 = perm_ref(st1, 12) ^ {64'hA5A5A5A5A5A5A5A5, 256'd0};
        check("b_load2_S", perm_S, st2);
        st3 = perm_ref(st2, 12) ^ {PAD, 256'd0};
        run_to_done(cyc, loads, rdy, ls);
        check("b_cycles", 320'(cyc), 320'(28));
        check("b_loads", 320'(loads), 320'(2));
        check("b_load3_S", ls, st3);
        check("b_msg_ready_hi", 320'(rdy), 320'(0));
        check("b_out_state", out_state, perm_ref(st3, 12));
        release_out();

        // Empty last block: padding only, a single permutation
        do_init(s0);
        send_block(64'hFFFFFFFFFFFFFFFF, 4'd0, 1'b1);
        st1 = s0 ^ {PAD, 256'd0};
        run_to_done(cyc, loads, rdy, ls);
        check("c_cycles", 320'(cyc), 320'(14));
        check("c_loads", 320'(loads), 320'(1));
        check("c_load_S", ls, st1);
        check("c_out_state", out_state, perm_ref(st1, 12));
        release_out();

        // ROUNDS = 6, msg_valid held high
        init_valid6 = 1'b1;
        n = 0;
        while (!init_ready6 && n < 20) begin tick(); n++; end
        tick();
        init_valid6 = 1'b0;
        msg_valid6 = 1'b1;
        n = 0;
        while (!msg_ready6 && n < 20) begin tick(); n++; end
        check("r6_first_ready", 320'(msg_ready6), 320'(1));
        tick();
        for (int unsigned g = 0; g < 3; g++) begin
            n = 0;
            while (!msg_ready6 && n < 40) begin tick(); n++; end
            check("r6_accept_to_ready", 320'(n), 320'(8));
            tick();
        end
        msg_valid6 = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
